// File: rtl/inverter_pipe_pkg.sv
// inverter_pipe_pkg: per-beat mode encoding and the bitwise operation shared by the pipeline
package inverter_pipe_pkg;

    typedef enum logic [1:0] {
        INV        = 2'b00,
        PASS       = 2'b01,
        MASKED_INV = 2'b10,
        ZERO       = 2'b11
    } inv_mode_e;

    // Works on one bit so the caller can apply it across any WIDTH without a width-fixed signature
    function automatic logic apply_mode(input logic data, input inv_mode_e mode, input logic mask);
        return (mode == INV)        ? ~data :
               (mode == PASS)       ? data :
               (mode == MASKED_INV) ? data ^ mask :
                                      1'b0;
    endfunction

endpackage

// File: rtl/inverter_pipe_stage.sv
// pipe_stage: one valid/data register slice with load enable; carries parity when INVERTER_PIPE_PARITY_EN is defined
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
`ifdef INVERTER_PIPE_PARITY_EN
    input  logic             parity_i,
    output logic             parity_o,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Slice register: loads upstream valid/data when the stage advances, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef INVERTER_PIPE_PARITY_EN
    logic parity_q;

    // Parity travels with its data word and is held under the same enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_q <= 1'b0;
        else if (load_i) parity_q <= parity_i;
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: rtl/inverter_pipe.sv
// inverter_pipe: elastic WIDTH x STAGES valid/ready pipeline applying a per-beat mode; INVERTER_PIPE_PARITY_EN adds out_parity
module inverter_pipe
    import inverter_pipe_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_mode,
    input  logic [WIDTH-1:0]   in_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
`ifdef INVERTER_PIPE_PARITY_EN
    output logic               out_parity,
`endif
    output logic [COUNT_W-1:0] beat_cnt,
    input  logic               cnt_clr
);

    // Chain index k is the input of stage k; index k+1 is its output
    logic [STAGES:0]    vc;
    logic [WIDTH-1:0]   dc [STAGES+1];
    logic [STAGES-1:0]  adv;
    logic [WIDTH-1:0]   op;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    // Processed word for the beat presented at the input
    always_comb begin
        op = '0;
        for (int i = 0; i < WIDTH; i++) op[i] = apply_mode(in_data[i], inv_mode_e'(in_mode), in_mask[i]);
    end

    // A stage may advance if it is empty or the stage after it advances (bubble collapsing)
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !vc[STAGES] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) adv[k] = !vc[k+1] || adv[k+1];
    end

    assign in_ready = rst_n && adv[0];
    assign vc[0]    = in_valid;
    assign dc[0]    = op;

`ifdef INVERTER_PIPE_PARITY_EN
    logic [STAGES:0] pc;
    assign pc[0]      = ^op;
    assign out_parity = pc[STAGES];
`endif

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (adv[g]),
            .valid_i  (vc[g]),
            .data_i   (dc[g]),
`ifdef INVERTER_PIPE_PARITY_EN
            .parity_i (pc[g]),
            .parity_o (pc[g+1]),
`endif
            .valid_o  (vc[g+1]),
            .data_o   (dc[g+1])
        );
    end

    assign out_valid = vc[STAGES];
    assign out_data  = dc[STAGES];

    // Clear wins over a coincident output handshake
    always_comb begin
        cnt_d = cnt_clr ? '0 : (out_valid && out_ready) ? cnt_q + COUNT_W'(1) : cnt_q;
    end

    // Output beat counter, wrapping naturally at 2^COUNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_inverter_pipe.sv
// tb_inverter_pipe: scoreboard bench for inverter_pipe (checks out_parity when INVERTER_PIPE_PARITY_EN is defined)
module tb_inverter_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, cnt_clr;
    logic [7:0]  in_data, in_mask;
    logic [1:0]  in_mode;
    logic        in_ready, out_valid, w_in_ready, w_out_valid;
    logic [7:0]  out_data, w_out_data;
    logic [15:0] beat_cnt;
    logic [3:0]  w_beat_cnt;
`ifdef INVERTER_PIPE_PARITY_EN
    logic        out_parity, w_out_parity;
`endif

    always #5 clk = ~clk;

    inverter_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
`ifdef INVERTER_PIPE_PARITY_EN
        .out_parity(out_parity),
`endif
        .beat_cnt(beat_cnt), .cnt_clr(cnt_clr)
    );

    // Same stimulus, narrow counter for wrap checks
    inverter_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(4)) u_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_mask(in_mask), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data),
`ifdef INVERTER_PIPE_PARITY_EN
        .out_parity(w_out_parity),
`endif
        .beat_cnt(w_beat_cnt), .cnt_clr(cnt_clr)
    );

    int          tot = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [8:0]  exp_q[$];
    int          inc_q[$];
    logic [15:0] cnt_m = '0;
    logic        acc, lat_on = 1'b0, stall_prev = 1'b0;
    logic [7:0]  prev_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mdl(input logic [7:0] d, input logic [1:0] m, input logic [7:0] mk);
        logic [7:0] r;
        case (m)
            2'd0:    r = ~d;
            2'd1:    r = d;
            2'd2:    r = d ^ mk;
            default: r = 8'h00;
        endcase
        return {^r, r};
    endfunction

    // One cycle from a falling edge: drive, observe, account for the handshakes of the next rising edge
    task automatic tick(input logic v, input logic [7:0] d, input logic [1:0] m, input logic [7:0] mk,
                        input logic ordy, input logic clr);
        logic [8:0]  e;
        logic [15:0] cw;
        int          ic;
        in_valid = v; in_data = d; in_mode = m; in_mask = mk; out_ready = ordy; cnt_clr = clr;
        #1;
        cw = cnt_m;
        chk("cnt", beat_cnt, cnt_m);
        chk("cnt_w", w_beat_cnt, cw[3:0]);
        if (stall_prev) chk("hold", out_data, prev_data);
        stall_prev = out_valid && !ordy;
        prev_data  = out_data;
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) chk("spurious_out", out_data, 32'hdead);
            else begin
                e  = exp_q.pop_front();
                ic = inc_q.pop_front();
                chk("data", out_data, e[7:0]);
                chk("data_w", w_out_data, e[7:0]);
`ifdef INVERTER_PIPE_PARITY_EN
                chk("parity", out_parity, e[8]);
`endif
                if (lat_on) chk("latency", cyc - ic, 2);
            end
        end
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back(mdl(d, m, mk));
            inc_q.push_back(cyc);
        end
        cnt_m = clr ? 16'd0 : cnt_m + 16'(out_valid && ordy);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0);
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] bp [4];
        logic [7:0] rd, rk;
        logic [1:0] rm;
        logic       rv;
        int         idx, sent, guard;
        bp = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_mask = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cnt", beat_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        @(negedge clk);

        // Stream of INV beats, unstalled latency 2
        lat_on = 1'b1;
        tick(1'b1, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'hA5, 2'd0, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'hFF, 2'd0, 8'h00, 1'b1, 1'b0);
        drain();
        lat_on = 1'b0;
        chk("stream_cnt", beat_cnt, 3);

        // Mode mix
        tick(1'b1, 8'h3C, 2'd1, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'h3C, 2'd2, 8'h0F, 1'b1, 1'b0);
        tick(1'b1, 8'h3C, 2'd3, 8'hFF, 1'b1, 1'b0);
        tick(1'b1, 8'h3C, 2'd0, 8'hFF, 1'b1, 1'b0);
        drain();

        // Backpressure: four beats offered, output blocked for five cycles
        tick(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b1);
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, bp[idx], 2'd1, 8'h00, 1'b0, 1'b0);
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", in_ready, 0);
        guard = 0;
        while (idx < 4 && guard < 20) begin
            tick(1'b1, bp[idx], 2'd1, 8'h00, 1'b1, 1'b0);
            if (acc) idx++;
            guard++;
        end
        chk("bp_sent", idx, 4);
        drain();
        chk("bp_cnt", beat_cnt, 4);

        // Random valid/ready against the scoreboard
        tick(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b1);
        sent = 0; guard = 0;
        while ((sent < 1000 || exp_q.size() != 0) && guard < 10000) begin
            rv = (sent < 1000) && ($urandom_range(0, 1) == 1);
            rd = 8'($urandom); rk = 8'($urandom); rm = 2'($urandom);
            tick(rv, rd, rm, rk, $urandom_range(0, 1) == 1, 1'b0);
            if (acc) sent++;
            guard++;
        end
        chk("rand_sent", sent, 1000);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_cnt", beat_cnt, 1000);
        chk("rand_cnt_w", w_beat_cnt, 1000 % 16);

        // Sixteen beats wrap the narrow counter
        tick(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b1);
        sent = 0; guard = 0;
        while (sent < 16 && guard < 40) begin
            tick(1'b1, 8'(sent), 2'd0, 8'h00, 1'b1, 1'b0);
            if (acc) sent++;
            guard++;
        end
        drain();
        chk("wrap_cnt_w", w_beat_cnt, 0);
        chk("wrap_cnt", beat_cnt, 16);

        // Asynchronous reset with two beats in flight
        tick(1'b1, 8'h55, 2'd1, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 8'h66, 2'd1, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_cnt", beat_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        exp_q.delete(); inc_q.delete(); cnt_m = '0; stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 8'h81, 2'd0, 8'h00, 1'b1, 1'b0);
        drain();
        chk("post_rst_cnt", beat_cnt, 1);

        // Clear coincident with an output handshake
        tick(1'b1, 8'h07, 2'd1, 8'h00, 1'b1, 1'b0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            tick(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, out_valid);
            guard++;
        end
        chk("clr_hs_cnt", beat_cnt, 0);
        chk("clr_hs_cnt_w", w_beat_cnt, 0);
        drain();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
